dequeue_register: RTL

- Receive-side counterpart of the transmit-side message packer in the serial link.
- Takes one physical-link word made of NumDatBlocks blocks. Each block carries a block control bit at bit 0; a 1 marks the first block of a message.
- Splits the word back into individual messages and emits them one per cycle, each right-aligned to block 0.
- Sits between the link-layer receive path and the AXIS consumer.

---
 rtl/dequeue_register_pkg.sv | 9 +
 rtl/dequeue_msg_extract.sv | 73 +++++++
 rtl/lzc.sv | 22 ++
 rtl/dequeue_register.sv | 92 +++++++++
 4 files changed

// File: rtl/dequeue_register_pkg.sv
// Shared helpers for the receive-side message dequeue register.
package dequeue_register_pkg;

  // Width needed to hold block indices and block counts 0..n.
  function automatic int unsigned blk_cntr_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dequeue_msg_extract.sv
// Combinational message extraction: locates the oldest pending message in
// the stored word and right-aligns its data fields to block 0.
module dequeue_msg_extract
  import dequeue_register_pkg::*;
#(
  parameter  int unsigned N         = 4,
  parameter  int unsigned BlockSize = 9,
  localparam int unsigned CntW      = blk_cntr_width(N),
  localparam int unsigned FieldW    = BlockSize - 1
) (
  input  logic [N-1:0]           start_mask,
  input  logic [N*BlockSize-1:0] word,
  output logic [CntW-1:0]        s,
  output logic [CntW-1:0]        e,
  output logic [N*FieldW-1:0]    data,
  output logic [CntW-1:0]        len
);

  logic [N*FieldW-1:0] fields;
  logic [N*FieldW-1:0] shifted;
  logic [N-1:0]        above;
  logic [N-1:0]        ctrl_bits;
  logic [CntW-1:0]     nxt;
  logic                s_empty;
  logic                nxt_empty;
  logic                unused_ctrl;

  // Strip the control bit from every block.
  always_comb begin
    fields    = '0;
    ctrl_bits = '0;
    for (int b = 0; b < int'(N); b++) begin
      fields[b*FieldW +: FieldW] = word[b*BlockSize+1 +: FieldW];
      ctrl_bits[b]               = word[b*BlockSize];
    end
  end

  // Control bits are already mirrored in start_mask.
  assign unused_ctrl = ^ctrl_bits;

  lzc #(.Width(N), .CntW(CntW)) i_lzc_start (
    .in_bits (start_mask),
    .cnt     (s),
    .empty   (s_empty)
  );

  // Pending starts strictly above s mark where the current message ends.
  always_comb begin
    above = '0;
    for (int i = 0; i < int'(N); i++) begin
      above[i] = start_mask[i] && (CntW'(i) > s);
    end
  end

  lzc #(.Width(N), .CntW(CntW)) i_lzc_next (
    .in_bits (above),
    .cnt     (nxt),
    .empty   (nxt_empty)
  );

  assign e   = nxt_empty ? CntW'(N - 1) : nxt - CntW'(1);
  assign len = s_empty ? '0 : (e - s + CntW'(1));

  // Barrel shift down by s blocks, then zero every block at or above len.
  always_comb begin
    shifted = fields >> (int'(s) * int'(FieldW));
    data    = '0;
    for (int b = 0; b < int'(N); b++) begin
      if (CntW'(b) < len) data[b*FieldW +: FieldW] = shifted[b*FieldW +: FieldW];
    end
  end

endmodule

// File: rtl/lzc.sv
// Lowest-set-bit finder: cnt is the index of the lowest 1 in in_bits,
// empty is high when no bit is set (cnt is then 0).
module lzc #(
  parameter int unsigned Width = 4,
  parameter int unsigned CntW  = 3
) (
  input  logic [Width-1:0] in_bits,
  output logic [CntW-1:0]  cnt,
  output logic             empty
);

  // Scan from the top so the last hit wins, leaving the lowest index.
  always_comb begin
    cnt = '0;
    for (int i = int'(Width) - 1; i >= 0; i--) begin
      if (in_bits[i]) cnt = CntW'(i);
    end
  end

  assign empty = ~|in_bits;

endmodule

// File: rtl/dequeue_register.sv
// Splits one received link word into its messages and streams them out
// one per cycle on an AXIS-style handshake.
module dequeue_register
  import dequeue_register_pkg::*;
#(
  parameter  int unsigned ClkDiv                    = 1,
  parameter  int unsigned MaxPossibleTransferSplits = 1,
  parameter  type         data_block_t              = logic [8:0],
  localparam int unsigned NumDatBlocks              = ClkDiv * MaxPossibleTransferSplits,
  localparam int unsigned BlockSize                 = $bits(data_block_t),
  localparam int unsigned FieldW                    = BlockSize - 1,
  localparam int unsigned CntW                      = blk_cntr_width(NumDatBlocks)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  input  logic [NumDatBlocks*BlockSize-1:0] data_i,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [NumDatBlocks*FieldW-1:0]    data_o,
  output logic [CntW-1:0]                   num_blocks_o,
  output logic                              empty_drop_o
);

  logic [NumDatBlocks*BlockSize-1:0] word_q;
  logic [NumDatBlocks-1:0]           start_q;
  logic                              full_q;
  logic                              drop_q;

  logic [NumDatBlocks-1:0]           ctrl_in;
  logic [NumDatBlocks-1:0]           clr_mask;
  logic [CntW-1:0]                   msg_s;
  logic [CntW-1:0]                   msg_e;
  logic [NumDatBlocks*FieldW-1:0]    msg_data;
  logic [CntW-1:0]                   msg_len;
  logic                              last_msg;
  logic                              accept;
  logic                              pop;

  // Gather incoming control bits and the one-hot of the message being popped.
  always_comb begin
    ctrl_in  = '0;
    clr_mask = '0;
    for (int i = 0; i < int'(NumDatBlocks); i++) begin
      ctrl_in[i]  = data_i[i*BlockSize];
      clr_mask[i] = (CntW'(i) == msg_s);
    end
  end

  dequeue_msg_extract #(.N(NumDatBlocks), .BlockSize(BlockSize)) i_extract (
    .start_mask (start_q),
    .word       (word_q),
    .s          (msg_s),
    .e          (msg_e),
    .data       (msg_data),
    .len        (msg_len)
  );

  // No start above s means the message runs to the top block.
  assign last_msg = (msg_e == CntW'(NumDatBlocks - 1));
  assign ready_o  = ~full_q | (ready_i & last_msg);
  assign accept   = valid_i & ready_o;
  assign pop      = full_q & ready_i;

  // Word storage and pending-start bookkeeping; a new word overrides the old.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_q  <= '0;
      start_q <= '0;
      full_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      if (accept) begin
        word_q  <= data_i;
        start_q <= ctrl_in;
        full_q  <= |ctrl_in;
        drop_q  <= ~|ctrl_in;
      end else if (pop) begin
        start_q <= start_q & ~clr_mask;
        if (last_msg) full_q <= 1'b0;
      end
    end
  end

  assign valid_o      = full_q;
  assign data_o       = full_q ? msg_data : '0;
  assign num_blocks_o = full_q ? msg_len : '0;
  assign empty_drop_o = drop_q;

endmodule
